cpu_commit_stage: RTL

//  Consumer (slave end) of the EX->commit pipeline bundle. Accepts one instruction per

---
 rtl/cpu_commit_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_commit_stage.sv
// Commit stage: takes one EX bundle per handshake, performs the data-memory access
// over a req/ack port, and issues a single-cycle writeback pulse to the register file.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module cpu_commit_stage #(
  parameter int REG_WIDTH   = `REG_WIDTH,
  parameter int NUM_REGS    = 32,
  parameter int ACK_TIMEOUT = 255,
  localparam int DEST_W     = $clog2(NUM_REGS),
  localparam int CNT_W      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mem_write,
  input  logic                 in_mem_read,
  input  logic                 in_mem_to_reg,
  input  logic                 in_reg_write,
  input  logic [REG_WIDTH-1:0] in_alu_result,
  input  logic [REG_WIDTH-1:0] in_rb_data,
  input  logic [DEST_W-1:0]    in_reg_dest,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic [DEST_W-1:0]    wb_reg_dest,
  output logic [REG_WIDTH-1:0] wb_data,
  output logic                 err_illegal,
  output logic                 err_timeout
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  // Bundle fields that must survive the memory access.
  typedef struct packed {
    logic                 is_load;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic [DEST_W-1:0]    dest;
    logic [REG_WIDTH-1:0] alu;
  } pend_t;

  localparam logic             TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = TIMEOUT_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  state_t           state;
  pend_t            pend;
  logic [CNT_W-1:0] wd_cnt;
  logic             running;

  // running holds in_ready low until the first edge after reset release.
  assign in_ready = running && (state == IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; the asynchronous reset drops dmem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend         <= '0;
      wd_cnt       <= '0;
      running      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_reg_dest  <= '0;
      wb_data      <= '0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      running  <= 1'b1;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_mem_read || in_mem_write) begin
              // A bundle flagged both load and store is issued as a store only.
              if (in_mem_read && in_mem_write) err_illegal <= 1'b1;
              pend.is_load    <= in_mem_read && !in_mem_write;
              pend.mem_to_reg <= in_mem_to_reg;
              pend.reg_write  <= in_reg_write;
              pend.dest       <= in_reg_dest;
              pend.alu        <= in_alu_result;
              dmem_req        <= 1'b1;
              dmem_we         <= in_mem_write;
              dmem_addr       <= in_alu_result;
              dmem_wdata      <= in_rb_data;
              wd_cnt          <= '0;
              state           <= MEM_WAIT;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= in_reg_write;
              wb_reg_dest  <= in_reg_dest;
              wb_data      <= in_alu_result;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= pend.reg_write;
            wb_reg_dest  <= pend.dest;
            wb_data      <= (pend.is_load && pend.mem_to_reg) ? dmem_rdata : pend.alu;
            state        <= IDLE;
          end else if (TIMEOUT_EN && wd_cnt == CNT_LIMIT) begin
            // Abort: the instruction retires without touching the register file.
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            err_timeout  <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_reg_dest  <= pend.dest;
            wb_data      <= pend.alu;
            state        <= IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
